jtkcpu_idxseq: RTL and testbench

//  Indexed-addressing sequencer for the KCPU. It takes the indexed postbyte, fetches any
//  8/16-bit offset bytes over the operand bus, and computes the effective address (EA).
//  It performs the indirect pointer read when required and issues auto-inc/dec register

---
 rtl/jtkcpu_idxseq_pkg.sv | 33 +++
 rtl/jtkcpu_idxseq_if.sv | 9 +
 rtl/jtkcpu_idxea_add.sv | 30 +++
 rtl/jtkcpu_idxseq.sv | 181 ++++++++++++++++++
 tb/tb_jtkcpu_idxseq.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/jtkcpu_idxseq_pkg.sv
// jtkcpu_idxseq_pkg: indexed-mode codes, register codes, FSM states and postbyte helpers
package jtkcpu_idxseq_pkg;
    localparam logic [3:0] IDX_MODE_PINC1 = 4'h0;
    localparam logic [3:0] IDX_MODE_PINC2 = 4'h1;
    localparam logic [3:0] IDX_MODE_PDEC1 = 4'h2;
    localparam logic [3:0] IDX_MODE_PDEC2 = 4'h3;
    localparam logic [3:0] IDX_MODE_R     = 4'h4;
    localparam logic [3:0] IDX_MODE_B     = 4'h5;
    localparam logic [3:0] IDX_MODE_A     = 4'h6;
    localparam logic [3:0] IDX_MODE_N8    = 4'h8;
    localparam logic [3:0] IDX_MODE_N16   = 4'h9;
    localparam logic [3:0] IDX_MODE_D     = 4'hB;
    localparam logic [3:0] IDX_MODE_PC8   = 4'hC;
    localparam logic [3:0] IDX_MODE_PC16  = 4'hD;
    localparam logic [3:0] IDX_MODE_EXT   = 4'hF;
    localparam logic [1:0] IDX_REG_X = 2'd0;
    localparam logic [1:0] IDX_REG_Y = 2'd1;
    localparam logic [1:0] IDX_REG_U = 2'd2;
    localparam logic [1:0] IDX_REG_S = 2'd3;
    typedef enum logic [2:0] {
        ST_IDLE, ST_OFS_HI, ST_OFS_LO, ST_CALC, ST_IND_HI, ST_IND_LO, ST_DONE
    } state_t;
    function automatic logic [1:0] ofs_bytes(input logic [7:0] pb);
        return !pb[7] ? 2'd0 :
               (pb[3:0] == IDX_MODE_N8 || pb[3:0] == IDX_MODE_PC8) ? 2'd1 :
               (pb[3:0] == IDX_MODE_N16 || pb[3:0] == IDX_MODE_PC16 || pb[3:0] == IDX_MODE_EXT) ? 2'd2 : 2'd0;
    endfunction
    function automatic logic pb_illegal(input logic [7:0] pb);
        return pb[7] && (pb[3:0] == 4'h7 || pb[3:0] == 4'hA || pb[3:0] == 4'hE ||
               (pb[4] && (pb[3:0] == IDX_MODE_PINC1 || pb[3:0] == IDX_MODE_PDEC1)) ||
               (!pb[4] && pb[3:0] == IDX_MODE_EXT));
    endfunction
endpackage

// File: rtl/jtkcpu_idxseq_if.sv
// jtkcpu_idxseq_if: operand read port between the indexed sequencer and memory
interface jtkcpu_idxseq_if #(parameter int AW = 16);
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ack;
    logic [7:0]    rd_data;
    modport master(output rd_req, rd_addr, input rd_ack, rd_data);
    modport slave(input rd_req, rd_addr, output rd_ack, rd_data);
endinterface

// File: rtl/jtkcpu_idxea_add.sv
// jtkcpu_idxea_add: selects base register/offset for the postbyte and sums them
module jtkcpu_idxea_add import jtkcpu_idxseq_pkg::*; #(parameter int AW = 16) (
    input  logic [7:0]    pb,
    input  logic [AW-1:0] x,
    input  logic [AW-1:0] y,
    input  logic [AW-1:0] u,
    input  logic [AW-1:0] s,
    input  logic [AW-1:0] pc,
    input  logic [7:0]    acc_a,
    input  logic [7:0]    acc_b,
    input  logic [15:0]   ofs,
    output logic [AW-1:0] ea
);
    logic [3:0]    m;
    logic [AW-1:0] r, base, off;
    always_comb begin
        m = pb[3:0];
        r = pb[6:5] == IDX_REG_X ? x : pb[6:5] == IDX_REG_Y ? y : pb[6:5] == IDX_REG_U ? u : s;
        base = !pb[7] ? r : (m == IDX_MODE_PC8 || m == IDX_MODE_PC16) ? pc : m == IDX_MODE_EXT ? '0 : r;
        off = !pb[7] ? AW'($signed(pb[4:0])) :
              m == IDX_MODE_PDEC1 ? '1 :
              m == IDX_MODE_PDEC2 ? ~AW'(1) :
              m == IDX_MODE_B ? AW'($signed(acc_b)) :
              m == IDX_MODE_A ? AW'($signed(acc_a)) :
              (m == IDX_MODE_N8 || m == IDX_MODE_PC8) ? AW'($signed(ofs[7:0])) :
              (m == IDX_MODE_N16 || m == IDX_MODE_PC16 || m == IDX_MODE_EXT) ? AW'(ofs) :
              m == IDX_MODE_D ? AW'({acc_a, acc_b}) : '0;
        ea = base + off;
    end
endmodule

// File: rtl/jtkcpu_idxseq.sv
// jtkcpu_idxseq: indexed-addressing sequencer (offset fetch, EA, indirect read, auto inc/dec)
module jtkcpu_idxseq import jtkcpu_idxseq_pkg::*; #(parameter int AW = 16) (
    input  logic           rst,
    input  logic           clk,
    input  logic           cen,
    input  logic           start,
    input  logic [7:0]     postbyte,
    input  logic [AW-1:0]  pc,
    input  logic [AW-1:0]  x,
    input  logic [AW-1:0]  y,
    input  logic [AW-1:0]  u,
    input  logic [AW-1:0]  s,
    input  logic [7:0]     acc_a,
    input  logic [7:0]     acc_b,
    jtkcpu_idxseq_if.master rd,
    output logic [AW-1:0]  ea,
    output logic [1:0]     pc_adv,
    output logic           wb_we,
    output logic [1:0]     wb_sel,
    output logic [AW-1:0]  wb_val,
    output logic           busy,
    output logic           done,
    output logic           illegal
);
    state_t        state_q, state_d;
    logic [7:0]    pb_q, pb_d, a_q, a_d, b_q, b_d, hi_q, hi_d;
    logic [AW-1:0] pc_q, pc_d, x_q, x_d, y_q, y_d, u_q, u_d, s_q, s_d;
    logic [AW-1:0] ea_q, ea_d, rd_addr_q, rd_addr_d, wb_val_q, wb_val_d;
    logic [AW-1:0] ea_calc, pc_base, r_in, delta;
    logic [15:0]   ofs_q, ofs_d;
    logic [1:0]    pc_adv_q, pc_adv_d, wb_sel_q, wb_sel_d, nb_in;
    logic          rd_req_q, rd_req_d, wb_we_q, wb_we_d, illegal_q, illegal_d;
    logic          ack, ill, ind;
    assign ack     = rd.rd_ack && rd_req_q;
    assign ill     = pb_illegal(pb_q);
    assign ind     = pb_q[7] && pb_q[4] && !ill;
    assign nb_in   = ofs_bytes(postbyte);
    assign pc_base = pc_q + AW'(pc_adv_q);
    assign r_in    = postbyte[6:5] == IDX_REG_X ? x : postbyte[6:5] == IDX_REG_Y ? y :
                     postbyte[6:5] == IDX_REG_U ? u : s;
    // auto modes: 0 +1, 1 +2, 2 -1, 3 -2
    assign delta   = postbyte[1] ? (postbyte[0] ? ~AW'(1) : '1) : AW'({postbyte[0], ~postbyte[0]});
    jtkcpu_idxea_add #(.AW(AW)) u_add (
        .pb(pb_q), .x(x_q), .y(y_q), .u(u_q), .s(s_q), .pc(pc_base),
        .acc_a(a_q), .acc_b(b_q), .ofs(ofs_q), .ea(ea_calc)
    );
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else if (cen) state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = nb_in == 2'd2 ? ST_OFS_HI : nb_in == 2'd1 ? ST_OFS_LO : ST_CALC;
            ST_OFS_HI: if (ack) state_d = ST_OFS_LO;
            ST_OFS_LO: if (ack) state_d = ST_CALC;
            ST_CALC:   state_d = ind ? ST_IND_HI : ST_DONE;
            ST_IND_HI: if (ack) state_d = ST_IND_LO;
            ST_IND_LO: if (ack) state_d = ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
    end
    always_comb begin
        done = state_q == ST_DONE;
        busy = state_q != ST_IDLE && state_q != ST_DONE;
    end
    always_comb begin
        pb_d = pb_q;
        pc_d = pc_q;
        x_d = x_q;
        y_d = y_q;
        u_d = u_q;
        s_d = s_q;
        a_d = a_q;
        b_d = b_q;
        ofs_d = ofs_q;
        hi_d = hi_q;
        ea_d = ea_q;
        pc_adv_d = pc_adv_q;
        rd_req_d = rd_req_q;
        rd_addr_d = rd_addr_q;
        wb_we_d = 1'b0;
        wb_sel_d = wb_sel_q;
        wb_val_d = wb_val_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: if (start) begin
                pb_d = postbyte;
                pc_d = pc;
                x_d = x;
                y_d = y;
                u_d = u;
                s_d = s;
                a_d = acc_a;
                b_d = acc_b;
                ofs_d = '0;
                pc_adv_d = '0;
                illegal_d = 1'b0;
                rd_req_d = nb_in != 2'd0;
                rd_addr_d = pc;
                wb_we_d = postbyte[7] && postbyte[3:2] == 2'b00;
                wb_sel_d = wb_we_d ? postbyte[6:5] : wb_sel_q;
                wb_val_d = wb_we_d ? r_in + delta : wb_val_q;
            end
            ST_OFS_HI: if (ack) begin
                ofs_d[15:8] = rd.rd_data;
                pc_adv_d = pc_adv_q + 2'd1;
                rd_addr_d = rd_addr_q + AW'(1);
            end
            ST_OFS_LO: if (ack) begin
                ofs_d[7:0] = rd.rd_data;
                pc_adv_d = pc_adv_q + 2'd1;
                rd_req_d = 1'b0;
            end
            ST_CALC: begin
                ea_d = ea_calc;
                rd_req_d = ind;
                rd_addr_d = ind ? ea_calc : rd_addr_q;
                illegal_d = ill;
            end
            ST_IND_HI: if (ack) begin
                hi_d = rd.rd_data;
                rd_addr_d = rd_addr_q + AW'(1);
            end
            ST_IND_LO: if (ack) begin
                ea_d = AW'({hi_q, rd.rd_data});
                rd_req_d = 1'b0;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pb_q <= '0;
            pc_q <= '0;
            x_q <= '0;
            y_q <= '0;
            u_q <= '0;
            s_q <= '0;
            a_q <= '0;
            b_q <= '0;
            ofs_q <= '0;
            hi_q <= '0;
            ea_q <= '0;
            pc_adv_q <= '0;
            rd_req_q <= 1'b0;
            rd_addr_q <= '0;
            wb_we_q <= 1'b0;
            wb_sel_q <= '0;
            wb_val_q <= '0;
            illegal_q <= 1'b0;
        end else if (cen) begin
            pb_q <= pb_d;
            pc_q <= pc_d;
            x_q <= x_d;
            y_q <= y_d;
            u_q <= u_d;
            s_q <= s_d;
            a_q <= a_d;
            b_q <= b_d;
            ofs_q <= ofs_d;
            hi_q <= hi_d;
            ea_q <= ea_d;
            pc_adv_q <= pc_adv_d;
            rd_req_q <= rd_req_d;
            rd_addr_q <= rd_addr_d;
            wb_we_q <= wb_we_d;
            wb_sel_q <= wb_sel_d;
            wb_val_q <= wb_val_d;
            illegal_q <= illegal_d;
        end
    end
    assign rd.rd_req  = rd_req_q;
    assign rd.rd_addr = rd_addr_q;
    assign ea         = ea_q;
    assign pc_adv     = pc_adv_q;
    assign wb_we      = wb_we_q;
    assign wb_sel     = wb_sel_q;
    assign wb_val     = wb_val_q;
    assign illegal    = illegal_q;
endmodule

// File: tb/tb_jtkcpu_idxseq.sv
// tb_jtkcpu_idxseq: table-driven vectors plus reset/cen/busy corner sequences
module tb_jtkcpu_idxseq;
    logic        clk = 1'b0, rst = 1'b1, cen = 1'b1, start = 1'b0;
    logic [7:0]  postbyte = 8'h00, acc_a = 8'h80, acc_b = 8'h05;
    logic [15:0] pc = 16'h2000, x = 16'h1000, y = 16'h8000, u = 16'h0001, s = 16'h4000;
    logic [15:0] ea, wb_val;
    logic [1:0]  pc_adv, wb_sel;
    logic        wb_we, busy, done, illegal;
    logic [7:0]  mem [0:65535];
    jtkcpu_idxseq_if #(.AW(16)) rd_if();
    jtkcpu_idxseq dut (
        .rst(rst), .clk(clk), .cen(cen), .start(start), .postbyte(postbyte), .pc(pc),
        .x(x), .y(y), .u(u), .s(s), .acc_a(acc_a), .acc_b(acc_b), .rd(rd_if),
        .ea(ea), .pc_adv(pc_adv), .wb_we(wb_we), .wb_sel(wb_sel), .wb_val(wb_val),
        .busy(busy), .done(done), .illegal(illegal)
    );
    always #5 clk = ~clk;
    typedef struct packed {
        logic [7:0]  pb;
        int          wt;
        logic [7:0]  op0;
        logic [7:0]  op1;
        logic [15:0] ea;
        int          adv;
        int          lat;
        int          nwb;
        logic [1:0]  wsel;
        logic [15:0] wval;
        logic        ill;
        logic        ind;
        logic [15:0] iaddr;
    } vec_t;
    vec_t v [20];
    int total = 0, bad = 0;
    int lat, nrd, nwb;
    logic [15:0] log_a [8];
    logic [15:0] wval, tmp;
    logic [1:0]  wsel;
    logic        stable, done_seen, busy1, ill1, busy_done, done_after;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic launch(input logic [7:0] pb);
        postbyte = pb;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask
    task automatic serve(input int wt);
        int w;
        logic fresh;
        logic [15:0] cur;
        w = 0; fresh = 1'b1; cur = '0;
        lat = 1; nrd = 0; nwb = 0; stable = 1'b1; wsel = '0; wval = '0;
        busy1 = busy; ill1 = illegal;
        while (!done && lat < 60) begin
            if (wb_we) begin
                nwb++;
                wsel = wb_sel;
                wval = wb_val;
            end
            if (rd_if.rd_req) begin
                if (fresh) begin
                    cur = rd_if.rd_addr;
                    fresh = 1'b0;
                end else if (rd_if.rd_addr !== cur) stable = 1'b0;
                if (w == wt) begin
                    rd_if.rd_ack = 1'b1;
                    rd_if.rd_data = mem[cur];
                    if (nrd < 8) log_a[nrd] = cur;
                    nrd++;
                    w = 0;
                    fresh = 1'b1;
                end else begin
                    rd_if.rd_ack = 1'b0;
                    w++;
                end
            end else rd_if.rd_ack = 1'b0;
            step();
            lat++;
        end
        rd_if.rd_ack = 1'b0;
        done_seen = done;
        busy_done = busy;
        step();
        done_after = done;
    endtask
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hFFFF] = 8'hAB; mem[16'h0000] = 8'hCD;
        mem[16'h8000] = 8'h55; mem[16'h8001] = 8'hAA;
        mem[16'h7FFE] = 8'h11; mem[16'h7FFF] = 8'h22;
        rd_if.rd_ack = 1'b0;
        rd_if.rd_data = 8'h00;
        //        pb     wt  op0    op1    ea         adv lat nwb wsel  wval       ill   ind   iaddr
        v[0]  = '{8'h1F, 0, 8'h00, 8'h00, 16'h0FFF, 0, 2,  0, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0000};
        v[1]  = '{8'hA9, 3, 8'h12, 8'h34, 16'h9234, 2, 10, 0, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0000};
        v[2]  = '{8'hC3, 0, 8'h00, 8'h00, 16'hFFFF, 0, 2,  1, 2'd2, 16'hFFFF, 1'b0, 1'b0, 16'h0000};
        v[3]  = '{8'h9F, 0, 8'hFF, 8'hFF, 16'hABCD, 2, 6,  0, 2'd0, 16'h0000, 1'b0, 1'b1, 16'hFFFF};
        v[4]  = '{8'h8C, 0, 8'h80, 8'h00, 16'h1F81, 1, 3,  0, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0000};
        v[5]  = '{8'h87, 0, 8'h00, 8'h00, 16'h1000, 0, 2,  0, 2'd0, 16'h0000, 1'b1, 1'b0, 16'h0000};
        v[6]  = '{8'h90, 0, 8'h00, 8'h00, 16'h1000, 0, 2,  1, 2'd0, 16'h1001, 1'b1, 1'b0, 16'h0000};
        v[7]  = '{8'h80, 0, 8'h00, 8'h00, 16'h1000, 0, 2,  1, 2'd0, 16'h1001, 1'b0, 1'b0, 16'h0000};
        v[8]  = '{8'hE1, 0, 8'h00, 8'h00, 16'h4000, 0, 2,  1, 2'd3, 16'h4002, 1'b0, 1'b0, 16'h0000};
        v[9]  = '{8'hA2, 0, 8'h00, 8'h00, 16'h7FFF, 0, 2,  1, 2'd1, 16'h7FFF, 1'b0, 1'b0, 16'h0000};
        v[10] = '{8'h85, 0, 8'h00, 8'h00, 16'h1005, 0, 2,  0, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0000};
        v[11] = '{8'hC6, 0, 8'h00, 8'h00, 16'hFF81, 0, 2,  0, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0000};
        v[12] = '{8'h8B, 0, 8'h00, 8'h00, 16'h9005, 0, 2,  0, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0000};
        v[13] = '{8'hE8, 0, 8'h7F, 8'h00, 16'h407F, 1, 3,  0, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0000};
        v[14] = '{8'h8D, 0, 8'h01, 8'h00, 16'h2102, 2, 4,  0, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0000};
        v[15] = '{8'h8F, 0, 8'h12, 8'h34, 16'h1234, 2, 4,  0, 2'd0, 16'h0000, 1'b1, 1'b0, 16'h0000};
        v[16] = '{8'hB4, 2, 8'h00, 8'h00, 16'h55AA, 0, 8,  0, 2'd0, 16'h0000, 1'b0, 1'b1, 16'h8000};
        v[17] = '{8'h70, 0, 8'h00, 8'h00, 16'h3FF0, 0, 2,  0, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0000};
        v[18] = '{8'h8A, 0, 8'h00, 8'h00, 16'h1000, 0, 2,  0, 2'd0, 16'h0000, 1'b1, 1'b0, 16'h0000};
        v[19] = '{8'hB3, 1, 8'h00, 8'h00, 16'h1122, 0, 6,  1, 2'd1, 16'h7FFE, 1'b0, 1'b1, 16'h7FFE};
        step(); step(); step();
        rst = 1'b0;
        check("rst ea", ea, 16'h0000);
        check("rst pc_adv", pc_adv, 2'd0);
        check("rst wb", {wb_we, wb_sel, wb_val}, 19'h0);
        check("rst rd_req", rd_if.rd_req, 1'b0);
        check("rst rd_addr", rd_if.rd_addr, 16'h0000);
        check("rst busy/done/ill", {busy, done, illegal}, 3'b000);
        for (int i = 0; i < 20; i++) begin
            mem[pc] = v[i].op0;
            mem[pc + 16'd1] = v[i].op1;
            launch(v[i].pb);
            serve(v[i].wt);
            check($sformatf("pb%02h ea", v[i].pb), ea, v[i].ea);
            check($sformatf("pb%02h pc_adv", v[i].pb), pc_adv, v[i].adv);
            check($sformatf("pb%02h latency", v[i].pb), lat, v[i].lat);
            check($sformatf("pb%02h done", v[i].pb), {done_seen, done_after}, 2'b10);
            check($sformatf("pb%02h busy", v[i].pb), {busy1, busy_done}, 2'b10);
            check($sformatf("pb%02h ill clr", v[i].pb), ill1, 1'b0);
            check($sformatf("pb%02h illegal", v[i].pb), illegal, v[i].ill);
            check($sformatf("pb%02h wb cnt", v[i].pb), nwb, v[i].nwb);
            if (v[i].nwb != 0) check($sformatf("pb%02h wb", v[i].pb), {wsel, wval}, {v[i].wsel, v[i].wval});
            check($sformatf("pb%02h nrd", v[i].pb), nrd, v[i].adv + (v[i].ind ? 2 : 0));
            check($sformatf("pb%02h addr stable", v[i].pb), stable, 1'b1);
            if (v[i].adv > 0) check($sformatf("pb%02h rd0", v[i].pb), log_a[0], pc);
            if (v[i].adv > 1) check($sformatf("pb%02h rd1", v[i].pb), log_a[1], pc + 16'd1);
            if (v[i].ind) begin
                tmp = v[i].iaddr + 16'd1;
                check($sformatf("pb%02h ind hi", v[i].pb), log_a[v[i].adv], v[i].iaddr);
                check($sformatf("pb%02h ind lo", v[i].pb), log_a[v[i].adv + 1], tmp);
            end
        end
        mem[16'h2000] = 8'h00;
        mem[16'h2001] = 8'h10;
        launch(8'hA9);
        postbyte = 8'h1F;
        start = 1'b1;
        step(); step(); step();
        check("busy start ign", {busy, rd_if.rd_req, rd_if.rd_addr}, {1'b1, 1'b1, 16'h2000});
        start = 1'b0;
        serve(0);
        check("busy start ea", ea, 16'h8010);
        launch(8'hC3);
        cen = 1'b0;
        step(); step(); step();
        check("cen freeze", {wb_we, busy, done}, 3'b110);
        cen = 1'b1;
        serve(0);
        check("cen ea", ea, 16'hFFFF);
        check("cen wb cnt", nwb, 1);
        mem[16'h2000] = 8'h12;
        launch(8'hA9);
        rd_if.rd_ack = 1'b1;
        rd_if.rd_data = mem[16'h2000];
        step();
        rd_if.rd_ack = 1'b0;
        check("mid req", {rd_if.rd_req, rd_if.rd_addr}, {1'b1, 16'h2001});
        rst = 1'b1;
        step();
        check("mid rst", {rd_if.rd_req, busy, done, wb_we}, 4'b0000);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post rst quiet", {done, wb_we, busy}, 3'b000);
        end
        launch(8'h1F);
        serve(0);
        check("post rst ea", ea, 16'h0FFF);
        check("post rst lat", lat, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
